// File: rtl/cpc_ram_bank_ctrl.sv
// cpc_ram_bank_ctrl: CPC RAM-expansion CPLD core.
// Decodes RAM-config port writes into cfg/bank, then maps each 16K Z80
// region onto internal RAM or an expansion SRAM page. EXT_W extra bank bits
// come from the inverted low port address bits (&7Fxx down to &78xx at EXT_W=3).
module cpc_ram_bank_ctrl #(
   parameter  int EXT_W   = 0,
   localparam int BANK_W  = 3 + EXT_W,
   localparam int HIADR_W = 5 + EXT_W
) (
   input  logic               CLK,
   input  logic               RESET_B,
   input  logic               MREQ_B,
   input  logic               IOREQ_B,
   input  logic               RD_B,
   input  logic               WR_B,
   input  logic               M1_B,
   input  logic               RFSH_B,
   input  logic               ROMEN_B,
   input  logic [15:0]        A,
   input  logic [7:0]         D,
   input  logic               dip_en,
   output logic [HIADR_W-1:0] HIADR,
   output logic               RAMCS_B,
   output logic               RAMWE_B,
   output logic               RAMDIS
);

   logic              port_hit;
   logic              iowr;
   logic [BANK_W-1:0] bank_new;
   logic              s1_q, s_prev_q, s_prev_d;
   logic              s2_d, latch;
   logic [2:0]        cfg_q;
   logic [BANK_W-1:0] bank_q;
   logic [2:0]        page;
   logic              sel;

   // RD_B and A[7:0] play no part in decode; tie them off explicitly.
   logic unused_ok;
   assign unused_ok = &{1'b0, RD_B, A[7:0]};

   generate
      if (EXT_W == 0) begin : g_base
         assign port_hit = (A[14:8] == 7'h7F);
         assign bank_new = D[5:3];
      end else begin : g_ext
         assign port_hit = &A[14:8+EXT_W];
         assign bank_new = {~A[8+EXT_W-1:8], D[5:3]};
      end
   endgenerate

   // Port write: no int-ack, upper data bits 11 (gate-array writes use other codes).
   assign iowr = ~IOREQ_B & ~WR_B & M1_B & ~A[15] & (D[7:6] == 2'b11) & port_hit;

   // The capture flop itself acts as the second sync stage, so the update
   // lands on the second rising edge after iowr asserts. s_prev stays set
   // while the raw strobe is still high, so a write already in flight when
   // reset releases is swallowed instead of latched.
   assign s2_d     = s1_q;
   assign latch    = s2_d & ~s_prev_q;
   assign s_prev_d = s2_d | (s_prev_q & iowr);

   // Synchroniser, one-shot edge detect and config/bank registers.
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         s1_q     <= 1'b0;
         s_prev_q <= 1'b1;
         cfg_q    <= 3'd0;
         bank_q   <= '0;
      end else begin
         s1_q     <= iowr;
         s_prev_q <= s_prev_d;
         if (latch) begin
            cfg_q  <= D[2:0];
            bank_q <= bank_new;
         end
      end
   end

   // Page table: region A[15:14] under the current cfg; pages 4..7 are expansion.
   always_comb begin
      page = {1'b0, A[15:14]};
      case (cfg_q)
         3'd0:    page = {1'b0, A[15:14]};
         3'd1:    page = (A[15:14] == 2'd3) ? 3'd7 : {1'b0, A[15:14]};
         3'd2:    page = {1'b1, A[15:14]};
         3'd3: begin
            case (A[15:14])
               2'd0:    page = 3'd0;
               2'd1:    page = 3'd3;
               2'd2:    page = 3'd2;
               default: page = 3'd7;
            endcase
         end
         default: page = (A[15:14] == 2'd1) ? cfg_q : {1'b0, A[15:14]};
      endcase
   end

   // Expansion select and SRAM/RAMDIS drive; nothing here is stored.
   always_comb begin
      sel     = dip_en & ~MREQ_B & RFSH_B & ROMEN_B & page[2];
      HIADR   = {bank_q, (sel ? page[1:0] : 2'b00)};
      RAMCS_B = ~sel;
      RAMWE_B = ~(sel & ~WR_B);
      RAMDIS  = sel;
   end

endmodule
